ex_wb_writeback: RTL and testbench
==================================

Name: ex_wb_writeback

Overview:
- Producer end of the EX/WB forwarding interface: EX/WB pipeline register plus architectural register file write port.
- Generates `ex_wb_reg_write`, `ex_wb_rd` and `ex_wb_data`, which the forwarding comparator and the EX operand mux consume.
- Commits results to an 8-entry register file.
- Serves two combinational read ports to ID, with write-through bypass.

Parameters:
- DATA_W, 8, datapath / register width
- NUM_REGS, 8, register count (address width fixed at 3)
- ZERO_REG, 0, 1 = R0 hardwired to zero and never a forwarding source
- CNT_W, 16, width of retire counter

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a real instruction this cycle
- ex_reg_write  in  1  EX instruction writes a register
- ex_rd  in  3  EX destination register
- ex_result  in  DATA_W  EX ALU/load result
- stall  in  1  inject bubble into EX/WB this cycle
- flush  in  1  kill EX instruction; inject bubble
- ex_wb_reg_write  out  1  WB entry will commit a write (to forwarding unit)
- ex_wb_rd  out  3  WB destination register
- ex_wb_data  out  DATA_W  WB result (forwarded value)
- rs_addr  in  3  read port A address
- rs_data  out  DATA_W  read port A data
- rt_addr  in  3  read port B address
- rt_data  out  DATA_W  read port B data
- retire_count  out  CNT_W  committed register writes since reset

Behaviour:
- Reset (async assert, sync release):
  - ex_wb_reg_write=0, ex_wb_rd=0, ex_wb_data=0.
  - All register-file entries = 0; retire_count=0.
  - Reset mid-write discards the pending write.
- Pipeline register load, every rising edge when not in reset:
  - load_wr = ex_valid & ex_reg_write & !stall & !flush.
  - If ZERO_REG=1, load_wr is also gated by (ex_rd!=0).
  - ex_wb_reg_write <= load_wr.
  - ex_wb_rd and ex_wb_data load ex_rd and ex_result when load_wr=1, else hold their previous values. A bubble changes only the write flag.
- stall and flush both inject a bubble; asserting both together is the same as one. The upstream stages are responsible for holding the EX instruction during a stall.
- Latency: EX inputs at cycle N appear on the ex_wb_* outputs during cycle N+1. The register file updates at the end of N+1 (the edge entering N+2).
- Commit: on each edge where ex_wb_reg_write=1, regfile[ex_wb_rd] <= ex_wb_data and retire_count increments. Each WB entry commits exactly once, because the register reloads every cycle.
- retire_count saturates at all-ones; it does not wrap.
- Reads are combinational, for each port independently:
  - If ex_wb_reg_write=1 and addr==ex_wb_rd, data=ex_wb_data (write-through bypass).
  - Otherwise data=regfile[addr].
  - If ZERO_REG=1 and addr==0, data=0 regardless.
- Back-to-back writes to the same rd: the later one wins; the bypass always shows the newest WB value.
- No internal state machine beyond the pipeline register, the file and the counter. No X may propagate on any output after reset.

Decomposition:
- Shared package: DATA_W default, REG_ADDR_W=3, NUM_REGS=8, and the R0 index constant (shared with the forwarding and decode logic).
- One sub-module: reg_file_8x, covering storage, the write port, the two bypassed read ports and the ZERO_REG handling.
- The pipeline register and retire counter live in the top level.

Test Plan:
1. Reset, then read all addresses -> rs_data=rt_data=0 and retire_count=0. With ex_valid=0 throughout, ex_wb_reg_write stays 0.
2. Basic commit:
   - Stimulus: ex_valid=1, ex_reg_write=1, ex_rd=3, ex_result=0xA5 at cycle N.
   - Cycle N+1: ex_wb_reg_write=1, ex_wb_rd=3, ex_wb_data=0xA5; rs_addr=3 reads 0xA5 via bypass.
   - Cycle N+2: rs_addr=3 reads 0xA5 from the file; retire_count=1.
3. Back-to-back writes to rd=5 (0x11, then 0x22) -> ex_wb_data shows 0x11 then 0x22. The final file value is 0x22 and retire_count increases by 2.
4. Stall and flush:
   - A write with stall=1 -> next cycle ex_wb_reg_write=0, ex_wb_rd/data unchanged, no commit, count unchanged.
   - Repeat with flush=1, then with both asserted -> same result each time.
5. ZERO_REG=1: write rd=0 with value 0x7F -> ex_wb_reg_write stays 0, reading address 0 returns 0, count unchanged. With ZERO_REG=0, the same write commits 0x7F.
6. Async reset:
   - Assert reset_n=0 mid-cycle while ex_wb_reg_write=1, with no clock edge between assertion and the check -> all outputs clear immediately and the pending write is lost.
   - Separately, preload retire_count near saturation (force) and issue 3 writes -> the count holds at 0xFFFF.

Source files
------------

// File: rtl/ex_wb_writeback_pkg.sv
// Shared constants for the EX/WB writeback slice. The forwarding and decode
// logic import the same register-address definitions.
package ex_wb_writeback_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int REG_ADDR_W   = 3;
  localparam int DEF_NUM_REGS = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t R0_IDX = '0;

  // Control half of the EX/WB entry; the data word is sized by the instance.
  typedef struct packed {
    logic      wr;
    reg_addr_t rd;
  } wb_ctl_t;

  function automatic logic is_r0(input reg_addr_t a);
    return a == R0_IDX;
  endfunction
endpackage

// File: rtl/ex_wb_writeback_reg_file_8x.sv
// Register file for the writeback slice: one write port and two combinational
// read ports. Each read port bypasses the in-flight write.
module reg_file_8x
  import ex_wb_writeback_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  reg_addr_t         waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_addr_t         rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  reg_addr_t         rt_addr,
  output logic [DATA_W-1:0] rt_data
);
  localparam int NPORTS = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NPORTS-1:0][REG_ADDR_W-1:0] raddr;
  logic [NPORTS-1:0][DATA_W-1:0] rdata;
  logic wr_en;

  assign wr_en = we & ~((ZERO_REG != 0) & is_r0(waddr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem <= '0;
    else if (wr_en) mem[waddr] <= wdata;
  end

  assign raddr   = {rt_addr, rs_addr};
  assign rs_data = rdata[0];
  assign rt_data = rdata[1];

  // R0 masking wins over the bypass so a hardwired zero can never forward.
  generate
    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
      assign rdata[p] = ((ZERO_REG != 0) && is_r0(raddr[p])) ? '0 :
                        (we && (raddr[p] == waddr))          ? wdata :
                                                               mem[raddr[p]];
    end
  endgenerate
endmodule

// File: rtl/ex_wb_writeback.sv
// EX/WB pipeline register, retire counter and register-file write port; the
// ex_wb_* outputs feed the forwarding comparator and EX operand mux.
module ex_wb_writeback
  import ex_wb_writeback_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  reg_addr_t         ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_wb_reg_write,
  output reg_addr_t         ex_wb_rd,
  output logic [DATA_W-1:0] ex_wb_data,
  input  reg_addr_t         rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  reg_addr_t         rt_addr,
  output logic [DATA_W-1:0] rt_data,
  output logic [CNT_W-1:0]  retire_count
);
  wb_ctl_t           wb_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [CNT_W-1:0]  retire_q;
  logic              load_wr;

  assign load_wr = ex_valid & ex_reg_write & ~stall & ~flush &
                   ~((ZERO_REG != 0) & is_r0(ex_rd));

  // A bubble clears only the write flag; rd/data keep the last real entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_q      <= '0;
      wb_data_q <= '0;
    end else begin
      wb_q.wr <= load_wr;
      if (load_wr) begin
        wb_q.rd   <= ex_rd;
        wb_data_q <= ex_result;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retire_q <= '0;
    else if (wb_q.wr && (retire_q != '1)) retire_q <= retire_q + 1'b1;
  end

  reg_file_8x #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wb_q.wr),
    .waddr   (wb_q.rd),
    .wdata   (wb_data_q),
    .rs_addr (rs_addr),
    .rs_data (rs_data),
    .rt_addr (rt_addr),
    .rt_data (rt_data)
  );

  assign ex_wb_reg_write = wb_q.wr;
  assign ex_wb_rd        = wb_q.rd;
  assign ex_wb_data      = wb_data_q;
  assign retire_count    = retire_q;
endmodule

// File: tb/tb_ex_wb_writeback.sv
// Bench for ex_wb_writeback: one instance with ZERO_REG=0 and one with
// ZERO_REG=1 share stimulus and are checked against a behavioural model.
module tb_ex_wb_writeback;
  logic       clk = 0;
  logic       reset_n;
  logic       ex_valid, ex_reg_write, stall, flush;
  logic [2:0] ex_rd, rs_addr, rt_addr;
  logic [7:0] ex_result;

  logic       wb_wr   [2];
  logic [2:0] wb_rd   [2];
  logic [7:0] wb_data [2];
  logic [7:0] rs_d    [2];
  logic [7:0] rt_d    [2];
  logic [15:0] cnt    [2];

  int total = 0;
  int bad   = 0;

  // model state, index 0 -> dut (ZERO_REG=0), 1 -> dut_z (ZERO_REG=1)
  bit        m_wr   [2];
  bit [2:0]  m_rd   [2];
  bit [7:0]  m_data [2];
  bit [7:0]  m_mem  [2][8];
  int        m_cnt  [2];

  always #5 clk = ~clk;

  ex_wb_writeback #(.ZERO_REG(0)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_result(ex_result), .stall(stall), .flush(flush),
    .ex_wb_reg_write(wb_wr[0]), .ex_wb_rd(wb_rd[0]), .ex_wb_data(wb_data[0]),
    .rs_addr(rs_addr), .rs_data(rs_d[0]), .rt_addr(rt_addr), .rt_data(rt_d[0]),
    .retire_count(cnt[0]));

  ex_wb_writeback #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_result(ex_result), .stall(stall), .flush(flush),
    .ex_wb_reg_write(wb_wr[1]), .ex_wb_rd(wb_rd[1]), .ex_wb_data(wb_data[1]),
    .rs_addr(rs_addr), .rs_data(rs_d[1]), .rt_addr(rt_addr), .rt_data(rt_d[1]),
    .retire_count(cnt[1]));

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 0; m_rd[k] = 0; m_data[k] = 0; m_cnt[k] = 0;
      for (int a = 0; a < 8; a++) m_mem[k][a] = 0;
    end
  endtask

  function automatic bit [7:0] model_read(input int k, input bit [2:0] a);
    if (k == 1 && a == 0) return 8'h00;
    if (m_wr[k] && m_rd[k] == a) return m_data[k];
    return m_mem[k][a];
  endfunction

  // One clock: commit what WB held, then capture what EX presents.
  task automatic tick();
    bit ld;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (m_wr[k]) begin
        m_mem[k][m_rd[k]] = m_data[k];
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end
      ld = ex_valid && ex_reg_write && !stall && !flush && !(k == 1 && ex_rd == 0);
      m_wr[k] = ld;
      if (ld) begin m_rd[k] = ex_rd; m_data[k] = ex_result; end
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit w, input bit [2:0] rd, input bit [7:0] res,
                       input bit s, input bit f);
    ex_valid = v; ex_reg_write = w; ex_rd = rd; ex_result = res; stall = s; flush = f;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    rs_addr = 0; rt_addr = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    for (int a = 0; a < 8; a++) begin
      rs_addr = 3'(a); rt_addr = 3'(7 - a); #1;
      total++; if (rs_d[0] !== 8'h00) begin bad++; $display("FAIL reset_rs a=%0d got=%h exp=00", a, rs_d[0]); end
      total++; if (rt_d[0] !== 8'h00) begin bad++; $display("FAIL reset_rt a=%0d got=%h exp=00", a, rt_d[0]); end
    end
    total++; if (cnt[0] !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0000", cnt[0]); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'($urandom), 3'($urandom), 8'($urandom), 0, 0);
      tick();
      total++; if (wb_wr[0] !== 1'b0) begin bad++; $display("FAIL idle_wr cyc=%0d got=%b exp=0", i, wb_wr[0]); end
    end
  endtask

  task automatic test_basic();
    int c0 = m_cnt[0];
    drive(1, 1, 3, 8'hA5, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rs_addr = 3; #1;
    total++; if (wb_wr[0] !== 1'b1) begin bad++; $display("FAIL basic_wr got=%b exp=1", wb_wr[0]); end
    total++; if (wb_rd[0] !== 3'd3) begin bad++; $display("FAIL basic_rd got=%0d exp=3", wb_rd[0]); end
    total++; if (wb_data[0] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", wb_data[0]); end
    total++; if (rs_d[0] !== 8'hA5) begin bad++; $display("FAIL basic_bypass got=%h exp=a5", rs_d[0]); end
    tick();
    total++; if (wb_wr[0] !== 1'b0) begin bad++; $display("FAIL basic_wr_after got=%b exp=0", wb_wr[0]); end
    total++; if (rs_d[0] !== 8'hA5) begin bad++; $display("FAIL basic_file got=%h exp=a5", rs_d[0]); end
    total++; if (int'(cnt[0]) !== c0 + 1) begin bad++; $display("FAIL basic_cnt got=%0d exp=%0d", cnt[0], c0 + 1); end
  endtask

  task automatic test_back_to_back();
    int c0 = m_cnt[0];
    drive(1, 1, 5, 8'h11, 0, 0);
    tick();
    total++; if (wb_data[0] !== 8'h11) begin bad++; $display("FAIL b2b_first got=%h exp=11", wb_data[0]); end
    drive(1, 1, 5, 8'h22, 0, 0);
    tick();
    rt_addr = 5; #1;
    total++; if (wb_data[0] !== 8'h22) begin bad++; $display("FAIL b2b_second got=%h exp=22", wb_data[0]); end
    total++; if (rt_d[0] !== 8'h22) begin bad++; $display("FAIL b2b_bypass got=%h exp=22", rt_d[0]); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (rt_d[0] !== 8'h22) begin bad++; $display("FAIL b2b_file got=%h exp=22", rt_d[0]); end
    total++; if (int'(cnt[0]) !== c0 + 2) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", cnt[0], c0 + 2); end
  endtask

  task automatic test_stall_flush();
    bit [2:0] prd;
    bit [7:0] pdata, old2;
    int c0;
    for (int mode = 1; mode < 4; mode++) begin
      prd = wb_rd[0]; pdata = wb_data[0]; c0 = m_cnt[0]; old2 = m_mem[0][2];
      drive(1, 1, 2, 8'($urandom) | 8'h80, mode[0], mode[1]);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      rs_addr = 2; #1;
      total++; if (wb_wr[0] !== 1'b0) begin bad++; $display("FAIL bubble_wr mode=%0d got=%b exp=0", mode, wb_wr[0]); end
      total++; if (wb_rd[0] !== prd) begin bad++; $display("FAIL bubble_rd mode=%0d got=%0d exp=%0d", mode, wb_rd[0], prd); end
      total++; if (wb_data[0] !== pdata) begin bad++; $display("FAIL bubble_data mode=%0d got=%h exp=%h", mode, wb_data[0], pdata); end
      tick();
      total++; if (rs_d[0] !== old2) begin bad++; $display("FAIL bubble_file mode=%0d got=%h exp=%h", mode, rs_d[0], old2); end
      total++; if (int'(cnt[0]) !== c0) begin bad++; $display("FAIL bubble_cnt mode=%0d got=%0d exp=%0d", mode, cnt[0], c0); end
    end
  endtask

  task automatic test_zero_reg();
    int c0 = m_cnt[0], c1 = m_cnt[1];
    drive(1, 1, 0, 8'h7F, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rs_addr = 0; rt_addr = 0; #1;
    total++; if (wb_wr[1] !== 1'b0) begin bad++; $display("FAIL zr_wr got=%b exp=0", wb_wr[1]); end
    total++; if (wb_wr[0] !== 1'b1) begin bad++; $display("FAIL nozr_wr got=%b exp=1", wb_wr[0]); end
    total++; if (rs_d[1] !== 8'h00) begin bad++; $display("FAIL zr_rs got=%h exp=00", rs_d[1]); end
    tick();
    total++; if (rt_d[1] !== 8'h00) begin bad++; $display("FAIL zr_rt got=%h exp=00", rt_d[1]); end
    total++; if (int'(cnt[1]) !== c1) begin bad++; $display("FAIL zr_cnt got=%0d exp=%0d", cnt[1], c1); end
    total++; if (rs_d[0] !== 8'h7F) begin bad++; $display("FAIL nozr_file got=%h exp=7f", rs_d[0]); end
    total++; if (int'(cnt[0]) !== c0 + 1) begin bad++; $display("FAIL nozr_cnt got=%0d exp=%0d", cnt[0], c0 + 1); end
  endtask

  task automatic test_random();
    bit [2:0] ra, rb;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 3'($urandom),
            8'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      tick();
      ra = 3'($urandom); rb = 3'($urandom);
      rs_addr = ra; rt_addr = rb; #1;
      for (int k = 0; k < 2; k++) begin
        total++; if (wb_wr[k] !== m_wr[k]) begin bad++; $display("FAIL rnd_wr k=%0d i=%0d got=%b exp=%b", k, i, wb_wr[k], m_wr[k]); end
        total++; if (wb_rd[k] !== m_rd[k]) begin bad++; $display("FAIL rnd_rd k=%0d i=%0d got=%0d exp=%0d", k, i, wb_rd[k], m_rd[k]); end
        total++; if (wb_data[k] !== m_data[k]) begin bad++; $display("FAIL rnd_data k=%0d i=%0d got=%h exp=%h", k, i, wb_data[k], m_data[k]); end
        total++; if (rs_d[k] !== model_read(k, ra)) begin bad++; $display("FAIL rnd_rs k=%0d i=%0d a=%0d got=%h exp=%h", k, i, ra, rs_d[k], model_read(k, ra)); end
        total++; if (rt_d[k] !== model_read(k, rb)) begin bad++; $display("FAIL rnd_rt k=%0d i=%0d a=%0d got=%h exp=%h", k, i, rb, rt_d[k], model_read(k, rb)); end
        total++; if (int'(cnt[k]) !== m_cnt[k]) begin bad++; $display("FAIL rnd_cnt k=%0d i=%0d got=%0d exp=%0d", k, i, cnt[k], m_cnt[k]); end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 6, 8'h3C, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rs_addr = 6; rt_addr = 6;
    #2 reset_n = 0;
    #1;
    model_reset();
    total++; if (wb_wr[0] !== 1'b0) begin bad++; $display("FAIL arst_wr got=%b exp=0", wb_wr[0]); end
    total++; if (wb_rd[0] !== 3'd0) begin bad++; $display("FAIL arst_rd got=%0d exp=0", wb_rd[0]); end
    total++; if (wb_data[0] !== 8'h00) begin bad++; $display("FAIL arst_data got=%h exp=00", wb_data[0]); end
    total++; if (cnt[0] !== 16'h0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", cnt[0]); end
    total++; if (rs_d[0] !== 8'h00) begin bad++; $display("FAIL arst_rs got=%h exp=00", rs_d[0]); end
    @(posedge clk);
    #1 reset_n = 1;
    tick();
    total++; if (rt_d[0] !== 8'h00) begin bad++; $display("FAIL arst_lost got=%h exp=00", rt_d[0]); end
    total++; if (cnt[0] !== 16'h0) begin bad++; $display("FAIL arst_cnt2 got=%0d exp=0", cnt[0]); end
  endtask

  task automatic test_saturation();
    force dut.retire_q = 16'hFFFD;
    #1 release dut.retire_q;
    m_cnt[0] = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3'(i + 1), 8'($urandom), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    total++; if (int'(cnt[0]) !== m_cnt[0]) begin bad++; $display("FAIL sat_model got=%h exp=%h", cnt[0], m_cnt[0]); end
    total++; if (cnt[0] !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", cnt[0]); end
    tick();
    total++; if (cnt[0] !== 16'hFFFF) begin bad++; $display("FAIL sat_hold2 got=%h exp=ffff", cnt[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall_flush();
    test_zero_reg();
    test_random();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
